gray_tracker: RTL

//  Downstream consumer of the 3-bit Gray counter stage. Samples the Gray code on Valid_In,

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray2bin.sv | 16 +
 rtl/gray_tracker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray tracker types, default width and Gray-to-binary helper
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Reference conversion for any Gray producer/consumer checks at the default width
  function automatic logic [GRAY_W-1:0] g2b(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter
module gray2bin
  import gray_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] binary
);

  // Each binary bit is the parity of the Gray bits at and above it
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign binary[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/gray_tracker.sv
// rtl/gray_tracker.sv - Gray step checker with wrap extension; GRAY_ERR_CNT_EN enables error counting/resync
module gray_tracker
  import gray_pkg::*;
#(
  parameter int W      = GRAY_W,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid_In,
  input  logic [W-1:0]      Gray_In,
  output logic [W-1:0]      Bin_Out,
  output logic [WRAP_W+W-1:0] Count_Out,
  output logic              Wrap,
  output logic              Locked,
`ifdef GRAY_ERR_CNT_EN
  output logic [7:0]        Err_Cnt,
`endif
  output logic              Error
);

  localparam logic [W-1:0] BIN_MAX = {W{1'b1}};

  state_t            state, state_nxt;
  logic [W-1:0]      prev, prev_nxt;
  logic [W-1:0]      bin, bin_nxt;
  logic [WRAP_W-1:0] wrap_cnt, wrap_cnt_nxt;
  logic              wrap, wrap_nxt;
  logic              error, error_nxt;
  logic [W-1:0]      gin_bin;
  logic [W-1:0]      bin_inc;
  logic [W-1:0]      diff;
  logic              one_bit;
`ifdef GRAY_ERR_CNT_EN
  logic [7:0]        err_cnt, err_cnt_nxt;
`endif

  gray2bin #(.W(W)) u_gray2bin (
    .gray   (Gray_In),
    .binary (gin_bin)
  );

  assign bin_inc = bin + W'(1);
  assign diff    = Gray_In ^ prev;
  // Exactly one bit differs: nonzero and a power of two
  assign one_bit = (diff != '0) && ((diff & (diff - W'(1))) == '0);

  // State and datapath registers; reset discards all history
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_UNLOCKED;
      prev     <= '0;
      bin      <= '0;
      wrap_cnt <= '0;
      wrap     <= 1'b0;
      error    <= 1'b0;
`ifdef GRAY_ERR_CNT_EN
      err_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      bin      <= bin_nxt;
      wrap_cnt <= wrap_cnt_nxt;
      wrap     <= wrap_nxt;
      error    <= error_nxt;
`ifdef GRAY_ERR_CNT_EN
      err_cnt  <= err_cnt_nxt;
`endif
    end
  end

  // Next-state: lock on first sample, accept only +1 Gray steps, flag anything else
  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    bin_nxt      = bin;
    wrap_cnt_nxt = wrap_cnt;
    wrap_nxt     = 1'b0;
    error_nxt    = error;
`ifdef GRAY_ERR_CNT_EN
    err_cnt_nxt  = err_cnt;
`endif
    case (state)
      ST_UNLOCKED: begin
        if (Valid_In) begin
          prev_nxt     = Gray_In;
          bin_nxt      = gin_bin;
          wrap_cnt_nxt = '0;
          state_nxt    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (Valid_In && (diff != '0)) begin
          if (one_bit && (gin_bin == bin_inc)) begin
            prev_nxt = Gray_In;
            bin_nxt  = gin_bin;
            if (bin == BIN_MAX) begin
              wrap_nxt     = 1'b1;
              wrap_cnt_nxt = wrap_cnt + WRAP_W'(1);
            end
          end else begin
            error_nxt = 1'b1;
`ifdef GRAY_ERR_CNT_EN
            // Resync to the offending sample and keep tracking
            err_cnt_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            prev_nxt    = Gray_In;
            bin_nxt     = gin_bin;
`else
            state_nxt   = ST_FAULT;
`endif
          end
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_UNLOCKED;
      end
    endcase
  end

  assign Bin_Out   = bin;
  assign Count_Out = {wrap_cnt, bin};
  assign Wrap      = wrap;
  assign Locked    = (state != ST_UNLOCKED);
  assign Error     = error;
`ifdef GRAY_ERR_CNT_EN
  assign Err_Cnt   = err_cnt;
`endif

endmodule
